// File: rtl/jpeg_rle_run_ctrl.sv
// JPEG AC run-length controller: coefficients in, (run,size,amp) symbols out.
// Optional blk_cnt output when JPEG_RLE_BLKCNT_EN is defined.
module jpeg_rle_run_ctrl #(
  parameter int AMP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [3:0]       din_size,
  input  logic [AMP_W-1:0] din_amp,
  input  logic             din_sob,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [3:0]       dout_run,
  output logic [3:0]       dout_size,
  output logic [AMP_W-1:0] dout_amp,
  output logic             dout_dc,
  output logic             dout_eob
`ifdef JPEG_RLE_BLKCNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    ZRL,
    SYM
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [5:0]       zcnt_q, zcnt_d;
  logic [1:0]       zrem_q, zrem_d;
  logic [3:0]       hrun_q, hrun_d;
  logic [3:0]       hsize_q, hsize_d;
  logic [AMP_W-1:0] hamp_q, hamp_d;
  logic             vld_q, vld_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       size_q, size_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             dc_q, dc_d;
  logic             eob_q, eob_d;
`ifdef JPEG_RLE_BLKCNT_EN
  logic             hlast_q, hlast_d;
  logic             last_q, last_d;
  logic [15:0]      blk_q, blk_d;
`endif

  logic       out_xfer;
  logic       acc;
  logic [5:0] cur_idx;
  logic       is_zero;

  assign din_ready = (state_q == RUN) &&
                     (!vld_q || dout_ready);
  assign out_xfer  = vld_q && dout_ready;
  assign acc       = din_valid && din_ready;
  assign cur_idx   = din_sob ? 6'd0 : idx_q;
  assign is_zero   = (din_size == 4'd0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    zcnt_d  = zcnt_q;
    zrem_d  = zrem_q;
    hrun_d  = hrun_q;
    hsize_d = hsize_q;
    hamp_d  = hamp_q;
    vld_d   = vld_q;
    run_d   = run_q;
    size_d  = size_q;
    amp_d   = amp_q;
    dc_d    = dc_q;
    eob_d   = eob_q;
`ifdef JPEG_RLE_BLKCNT_EN
    hlast_d = hlast_q;
    last_d  = last_q;
    blk_d   = blk_q;
    if (out_xfer && last_q) begin
      blk_d = blk_q + 16'd1;
    end
`endif
    case (state_q)
      RUN: begin
        if (out_xfer) begin
          vld_d = 1'b0;
        end
        if (acc) begin
          idx_d = cur_idx + 6'd1;
          if (cur_idx == 6'd0) begin
            vld_d  = 1'b1;
            run_d  = 4'd0;
            size_d = din_size;
            amp_d  = din_amp;
            dc_d   = 1'b1;
            eob_d  = 1'b0;
            zcnt_d = 6'd0;
`ifdef JPEG_RLE_BLKCNT_EN
            last_d = 1'b0;
`endif
          end else if (is_zero && cur_idx != 6'd63) begin
            zcnt_d = zcnt_q + 6'd1;
          end else if (is_zero) begin
            // last slot is zero: pending zeros collapse into EOB
            vld_d  = 1'b1;
            run_d  = 4'd0;
            size_d = 4'd0;
            amp_d  = '0;
            dc_d   = 1'b0;
            eob_d  = 1'b1;
            zcnt_d = 6'd0;
`ifdef JPEG_RLE_BLKCNT_EN
            last_d = 1'b1;
`endif
          end else if (zcnt_q < 6'd16) begin
            vld_d  = 1'b1;
            run_d  = zcnt_q[3:0];
            size_d = din_size;
            amp_d  = din_amp;
            dc_d   = 1'b0;
            eob_d  = 1'b0;
            zcnt_d = 6'd0;
`ifdef JPEG_RLE_BLKCNT_EN
            last_d = (cur_idx == 6'd63);
`endif
          end else begin
            // first ZRL goes out now, the rest are counted in zrem
            hrun_d  = zcnt_q[3:0];
            hsize_d = din_size;
            hamp_d  = din_amp;
            zrem_d  = zcnt_q[5:4] - 2'd1;
            vld_d   = 1'b1;
            run_d   = 4'd15;
            size_d  = 4'd0;
            amp_d   = '0;
            dc_d    = 1'b0;
            eob_d   = 1'b0;
            zcnt_d  = 6'd0;
            state_d = ZRL;
`ifdef JPEG_RLE_BLKCNT_EN
            hlast_d = (cur_idx == 6'd63);
            last_d  = 1'b0;
`endif
          end
        end
      end
      ZRL: begin
        if (out_xfer) begin
          if (zrem_q != 2'd0) begin
            zrem_d = zrem_q - 2'd1;
          end else begin
            run_d   = hrun_q;
            size_d  = hsize_q;
            amp_d   = hamp_q;
            state_d = SYM;
`ifdef JPEG_RLE_BLKCNT_EN
            last_d  = hlast_q;
`endif
          end
        end
      end
      SYM: begin
        if (out_xfer) begin
          vld_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      idx_q   <= '0;
      zcnt_q  <= '0;
      zrem_q  <= '0;
      hrun_q  <= '0;
      hsize_q <= '0;
      hamp_q  <= '0;
      vld_q   <= 1'b0;
      run_q   <= '0;
      size_q  <= '0;
      amp_q   <= '0;
      dc_q    <= 1'b0;
      eob_q   <= 1'b0;
`ifdef JPEG_RLE_BLKCNT_EN
      hlast_q <= 1'b0;
      last_q  <= 1'b0;
      blk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      zcnt_q  <= zcnt_d;
      zrem_q  <= zrem_d;
      hrun_q  <= hrun_d;
      hsize_q <= hsize_d;
      hamp_q  <= hamp_d;
      vld_q   <= vld_d;
      run_q   <= run_d;
      size_q  <= size_d;
      amp_q   <= amp_d;
      dc_q    <= dc_d;
      eob_q   <= eob_d;
`ifdef JPEG_RLE_BLKCNT_EN
      hlast_q <= hlast_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
`endif
    end
  end

  assign dout_valid = vld_q;
  assign dout_run   = run_q;
  assign dout_size  = size_q;
  assign dout_amp   = amp_q;
  assign dout_dc    = dc_q;
  assign dout_eob   = eob_q;
`ifdef JPEG_RLE_BLKCNT_EN
  assign blk_cnt    = blk_q;
`endif

endmodule

// File: tb/tb_jpeg_rle_run_ctrl.sv
// Bench for jpeg_rle_run_ctrl: cycle table, directed blocks, random blocks
// against a symbol-list model.
module tb_jpeg_rle_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [3:0]  din_size = '0;
  logic [11:0] din_amp = '0;
  logic        din_sob = 1'b0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [3:0]  dout_run;
  logic [3:0]  dout_size;
  logic [11:0] dout_amp;
  logic        dout_dc;
  logic        dout_eob;
`ifdef JPEG_RLE_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  jpeg_rle_run_ctrl #(.AMP_W(12)) dut (
    .clk(clk),
    .rst(rst),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din_size(din_size),
    .din_amp(din_amp),
    .din_sob(din_sob),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_run(dout_run),
    .dout_size(dout_size),
    .dout_amp(dout_amp),
    .dout_dc(dout_dc),
    .dout_eob(dout_eob)
`ifdef JPEG_RLE_BLKCNT_EN
    ,
    .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        eob;
    logic        dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
  } sym_t;

  typedef struct {
    logic        v;
    logic        sob;
    logic [3:0]  sz;
    logic [11:0] am;
    logic        rdy;
    logic        e_dr;
    logic        e_vld;
    sym_t        e_sym;
  } vec_t;

  typedef struct {
    logic        sob;
    logic [3:0]  sz;
    logic [11:0] am;
  } coef_t;

  int   checks = 0;
  int   errors = 0;
  sym_t got_q[$];
  sym_t exp_q[$];
  int   nfull = 0;

  function automatic sym_t mk(logic e, logic d, logic [3:0] r,
                              logic [3:0] s, logic [11:0] a);
    sym_t x;
    x.eob = e; x.dc = d; x.run = r; x.size = s; x.amp = a;
    return x;
  endfunction

  function automatic sym_t cur_sym();
    return mk(dout_eob, dout_dc, dout_run, dout_size, dout_amp);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic sob,
                       input logic [3:0] sz, input logic [11:0] am,
                       input logic rdy, output logic acc, output logic dr);
    @(negedge clk);
    din_valid = v; din_sob = sob; din_size = sz;
    din_amp = am; dout_ready = rdy;
    #1;
    dr  = din_ready;
    acc = v && din_ready;
    if (dout_valid && dout_ready) got_q.push_back(cur_sym());
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sob, input logic [3:0] sz,
                      input logic [11:0] am);
    logic a, d;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, sob, sz, am, 1'b1, a, d);
      n++;
    end
    chk("send_accept", {31'd0, a}, 32'd1);
  endtask

  task automatic drain(input int n);
    logic a, d;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 12'd0, 1'b1, a, d);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 4'd0, 12'd0);
  endtask

  task automatic compare_q(string nm);
    int n;
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(nm, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; din_sob = 1'b0;
    #1;
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_sym", 32'(cur_sym()), 32'd0);
`ifdef JPEG_RLE_BLKCNT_EN
    chk("rst_blk", {16'd0, blk_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  // Expected symbols for one block starting at index 0 of length len.
  task automatic model_block(input int len, input logic [3:0] sz[64],
                             input logic [11:0] am[64]);
    int z;
    z = 0;
    exp_q.push_back(mk(0, 1, 0, sz[0], am[0]));
    for (int i = 1; i < len; i++) begin
      if (sz[i] == 0) begin
        z++;
        if (i == 63) exp_q.push_back(mk(1, 0, 0, 0, 0));
      end else begin
        for (int k = 0; k < z / 16; k++) exp_q.push_back(mk(0, 0, 15, 0, 0));
        exp_q.push_back(mk(0, 0, 4'(z % 16), sz[i], am[i]));
        z = 0;
      end
    end
    if (len == 64) nfull++;
  endtask

  vec_t tbl[6];

  initial begin
    logic a, d;
    tbl[0] = '{1, 1, 3, 5, 1, 1, 1, mk(0, 1, 0, 3, 5)};
    tbl[1] = '{1, 0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0)};
    tbl[2] = '{1, 0, 2, 3, 1, 1, 1, mk(0, 0, 1, 2, 3)};
    tbl[3] = '{1, 0, 1, 1, 0, 0, 1, mk(0, 0, 1, 2, 3)};
    tbl[4] = '{1, 0, 1, 1, 1, 1, 1, mk(0, 0, 0, 1, 1)};
    tbl[5] = '{0, 0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0)};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din_valid = tbl[i].v; din_sob = tbl[i].sob; din_size = tbl[i].sz;
      din_amp = tbl[i].am; dout_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_din_ready", i), {31'd0, din_ready},
          {31'd0, tbl[i].e_dr});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, dout_valid},
          {31'd0, tbl[i].e_vld});
      if (tbl[i].e_vld)
        chk($sformatf("tbl%0d_sym", i), 32'(cur_sym()), 32'(tbl[i].e_sym));
    end

    do_reset();
    send(1, 3, 5);
    zeros(63);
    drain(3);
    exp_q.push_back(mk(0, 1, 0, 3, 5));
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    compare_q("dc_eob");

    do_reset();
    send(1, 1, 1);
    zeros(20);
    send(0, 2, 3);
    cycle(1, 0, 1, 1, 1, a, d);
    chk("zrl_din_ready", {31'd0, d}, 32'd0);
    drain(3);
    exp_q.push_back(mk(0, 1, 0, 1, 1));
    exp_q.push_back(mk(0, 0, 15, 0, 0));
    exp_q.push_back(mk(0, 0, 4, 2, 3));
    compare_q("one_zrl");

    do_reset();
    send(1, 2, 7);
    zeros(62);
    send(0, 1, 1);
    drain(6);
    exp_q.push_back(mk(0, 1, 0, 2, 7));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 15, 0, 0));
    exp_q.push_back(mk(0, 0, 14, 1, 1));
    compare_q("idx63_nz");

    do_reset();
    send(1, 0, 0);
    zeros(40);
    zeros(23);
    drain(3);
    exp_q.push_back(mk(0, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    compare_q("drop_zrl");

    do_reset();
    cycle(1, 1, 4, 9, 0, a, d);
    chk("stall_first_acc", {31'd0, a}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 1, 0, a, d);
      chk("stall_din_ready", {31'd0, d}, 32'd0);
      chk("stall_valid", {31'd0, dout_valid}, 32'd1);
      chk("stall_sym", 32'(cur_sym()), 32'(mk(0, 1, 0, 4, 9)));
    end
    cycle(1, 0, 1, 1, 1, a, d);
    chk("stall_release_acc", {31'd0, a}, 32'd1);
    drain(3);
    exp_q.push_back(mk(0, 1, 0, 4, 9));
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    compare_q("stall");

    do_reset();
    send(1, 1, 1);
    zeros(20);
    send(0, 2, 3);
    @(negedge clk);
    dout_ready = 1'b0; din_valid = 1'b0;
    #1;
    chk("pre_rst_zrl", 32'(cur_sym()), 32'(mk(0, 0, 15, 0, 0)));
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("async_rst_sym", 32'(cur_sym()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    send(0, 2, 2);
    zeros(63);
    drain(3);
    exp_q.push_back(mk(0, 1, 0, 2, 2));
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    compare_q("after_rst");

    do_reset();
    nfull = 0;
    begin
      coef_t       cq[$];
      logic [3:0]  sz[64];
      logic [11:0] am[64];
      int          len, p, n;
      logic        v;
      for (int b = 0; b < 40; b++) begin
        len = ($urandom % 5 == 0) ? $urandom_range(1, 63) : 64;
        p = $urandom_range(2, 14);
        for (int i = 0; i < 64; i++) begin
          if (i == 0 || $urandom % p == 0) sz[i] = 4'($urandom_range(0, 11));
          else sz[i] = 4'd0;
          am[i] = (sz[i] == 0) ? 12'd0 : 12'($urandom);
        end
        model_block(len, sz, am);
        for (int i = 0; i < len; i++) cq.push_back('{i == 0, sz[i], am[i]});
      end
      foreach (cq[j]) begin
        a = 1'b0;
        n = 0;
        while (!a && n < 200) begin
          v = ($urandom % 4 != 0);
          cycle(v, cq[j].sob, cq[j].sz, cq[j].am,
                ($urandom % 10 < 7), a, d);
          n++;
        end
        if (!a) chk("rand_accept_timeout", 32'd0, 32'd1);
      end
      drain(10);
      compare_q("random");
`ifdef JPEG_RLE_BLKCNT_EN
      chk("blk_cnt", {16'd0, blk_cnt}, 32'(nfull));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_run_ctrl.md
JPEG_RLE_RUN_CTRL -- requirements
Module: jpeg_rle_run_ctrl

Interface
REQ-001 SHALL have parameter AMP_W, default 12, which sets the coefficient amplitude width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port din_valid, input, 1 bit: the input coefficient is valid.
REQ-005 SHALL have port din_ready, output, 1 bit: the block can accept an input coefficient.
REQ-006 SHALL have port din_size, input, 4 bits: the coefficient size category; 0 means a zero coefficient.
REQ-007 SHALL have port din_amp, input, AMP_W bits: the coefficient amplitude bits.
REQ-008 SHALL have port din_sob, input, 1 bit: start of block; it is high with the DC coefficient (index 0).
REQ-009 SHALL have port dout_valid, output, 1 bit: the output symbol is valid.
REQ-010 SHALL have port dout_ready, input, 1 bit: the downstream can accept the output symbol.
REQ-011 SHALL have port dout_run, output, 4 bits: the zero-run length preceding the symbol.
REQ-012 SHALL have port dout_size, output, 4 bits: the symbol size category.
REQ-013 SHALL have port dout_amp, output, AMP_W bits: the symbol amplitude.
REQ-014 SHALL have port dout_dc, output, 1 bit: the symbol is the DC term.
REQ-015 SHALL have port dout_eob, output, 1 bit: the symbol is an end-of-block marker.

Function
REQ-016 SHALL transfer an input coefficient on din_valid&&din_ready, and transfer an output symbol on dout_valid&&dout_ready.
REQ-017 SHALL drive din_ready = (state==RUN) && (!dout_valid || dout_ready).
REQ-018 SHALL track the coefficient index idx[5:0]:
- A coefficient accepted with din_sob set loads idx=0 and clears zcnt.
- Each other accepted coefficient increments idx.
- idx wraps from 63 to 0.
REQ-019 SHALL have the following states:
- RUN: accept coefficients.
- ZRL: emit pending ZRL symbols.
- SYM: emit the held symbol.
REQ-020 SHALL, for a coefficient at idx 0: emit it next cycle with dout_dc=1, run=0, and size/amp passed through, even when size=0.
REQ-021 SHALL, for an AC zero coefficient (size=0, idx 1..62): increment zcnt[5:0] and emit nothing.
REQ-022 SHALL, for an AC nonzero coefficient with zcnt<16: emit the symbol next cycle with run=zcnt, then clear zcnt.
REQ-023 SHALL, for an AC nonzero coefficient with zcnt>=16:
- Latch size, amp and run=zcnt[3:0].
- Go to ZRL and emit zcnt[5:4] ZRL symbols (run=15, size=0, amp=0), one per output transfer.
- Then go to SYM, emit the latched symbol, and return to RUN.
REQ-024 SHALL, when idx 63 is zero: discard all pending zeros and deferred ZRLs, emit one EOB (run=0, size=0, dout_eob=1), and clear zcnt.
REQ-025 SHALL, when idx 63 is nonzero: emit the symbol per REQ-022/023 and emit no EOB.
REQ-026 SHALL register all outputs; dout_* SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-027 SHALL give 1 cycle latency from input acceptance to dout_valid when there is no ZRL and no stall.
REQ-028 SHALL, when dout_ready is high on every cycle, deliver k ZRLs plus the symbol over k+1 consecutive cycles.
REQ-029 SHALL, when din_sob arrives at idx!=0 (a short block): restart the index without emitting an EOB for the truncated block.

Reset
REQ-030 SHALL, while rst=0, immediately force:
- state=RUN, idx=0, zcnt=0;
- dout_valid=0, dout_run=0, dout_size=0, dout_amp=0, dout_dc=0, dout_eob=0.
REQ-031 SHALL drop any in-flight ZRL or held symbol on reset without emitting it.
REQ-032 SHALL treat the first coefficient after reset release as idx 0 regardless of din_sob.

Configuration
REQ-033 SHALL, with JPEG_RLE_BLKCNT_EN defined, add output port blk_cnt[15:0]:
- blk_cnt increments when the EOB or idx-63 symbol transfers.
- It wraps 65535->0.
- It resets to 0.
REQ-034 SHALL, without JPEG_RLE_BLKCNT_EN defined, have no port blk_cnt, and all other behaviour SHALL be identical.

Verification
REQ-035 SHALL pass: DC size=3, amp=5, then 63 zeros -> (dc, 0/3/5), then EOB at the idx-63 transfer; no ZRLs.
REQ-036 SHALL pass: DC, 20 zeros, AC size=2 amp=3 at idx 21 -> DC, ZRL(15/0), then (4/2/3); din_ready low during the ZRL cycle.
REQ-037 SHALL pass: DC, 62 zeros, idx 63 size=1 amp=1 -> DC, 3 ZRLs, then (14/1/1); no EOB.
REQ-038 SHALL pass: DC, 40 zeros, rest zero -> DC then EOB only; the 2 deferred ZRLs are discarded.
REQ-039 SHALL pass: dout_ready held low for 5 cycles with a symbol pending -> outputs stable, din_ready=0, no symbol lost or duplicated.
REQ-040 SHALL pass: rst pulsed low in the ZRL state -> all outputs 0 asynchronously; the next block encodes correctly from idx 0.
